vc_mem_port_arbiter: RTL
========================

VC_MEM_PORT_ARBITER -- requirements
Module: vc_mem_port_arbiter

Interface
REQ-001 SHALL have parameter p_num_ports, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter p_addr_sz, default 8, memory message address width in bits.
REQ-003 SHALL have parameter p_data_sz, default 32, memory message data width in bits.
REQ-004 SHALL have parameter p_max_outstanding, default 4, depth of the port-ID queue (power of 2).
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port reqs_val, input, p_num_ports, requester request valid per port.
REQ-009 SHALL have port reqs_rdy, output, p_num_ports, requester request ready per port.
REQ-010 SHALL have port reqs_msg, input, p_num_ports*c_req_msg_sz, request messages; port i occupies slice i.
REQ-011 SHALL have port resps_val, output, p_num_ports, response valid per port.
REQ-012 SHALL have port resps_rdy, input, p_num_ports, response ready per port.
REQ-013 SHALL have port resps_msg, output, p_num_ports*c_resp_msg_sz, response messages.
REQ-014 SHALL have port memreq_val/memreq_rdy/memreq_msg, output/input/output, 1/1/c_req_msg_sz, downstream memory request.
REQ-015 SHALL have port memresp_val/memresp_rdy/memresp_msg, input/output/input, 1/1/c_resp_msg_sz, downstream memory response.

Function
REQ-016 SHALL grant, when unlocked, the first valid port at or after priority pointer ptr, wrapping from p_num_ports-1 to 0 (non-power-of-2 included).
REQ-017 SHALL drive memreq_val = (any reqs_val or locked) and queue not full; memreq_msg = granted port's slice; zero-cycle latency.
REQ-018 SHALL assert reqs_rdy only for the granted port, equal to memreq_rdy and queue not full.
REQ-019 SHALL set lock and hold the grant when memreq_val is high and memreq_rdy low; grant unchanged until transfer completes.
REQ-020 SHALL on request transfer: push granted ID, set ptr to (grant+1) mod p_num_ports, clear lock.
REQ-021 SHALL route responses in order: resps_val[head] = memresp_val and queue not empty; others 0; memresp_rdy = resps_rdy[head] and not empty.
REQ-022 SHALL broadcast memresp_msg on every resps_msg slice.
REQ-023 SHALL pop head on response transfer; response path zero-cycle latency.
REQ-024 SHALL block push when full even if a pop occurs the same cycle; push and pop together when not full leave count unchanged.
REQ-025 SHALL drop memresp_val arriving with empty queue (memresp_rdy=0, never accepted).

Reset
REQ-026 SHALL on reset: ptr=0, lock=0, queue empty; memreq_val, reqs_rdy, resps_val, memresp_rdy all 0 while reset high.
REQ-027 SHALL discard outstanding IDs on reset mid-operation; first post-reset grant starts from port 0.

Configuration
REQ-028 SHALL, with VC_MEM_PORT_ARBITER_ASSERT_EN defined, $display an error and $finish on: memresp_val with empty queue, locked grant port dropping reqs_val, p_num_ports out of range.
REQ-029 SHALL, without VC_MEM_PORT_ARBITER_ASSERT_EN, contain no checks; functional behaviour identical.

Structure
REQ-030 SHALL derive c_req_msg_sz/c_resp_msg_sz from VC_MEM_REQ_MSG_SZ/VC_MEM_RESP_MSG_SZ in the shared message headers; no new message macros.
REQ-031 SHALL place ID queue in sub-module vc_mem_port_arb_id_queue (clog2(p_num_ports)-bit entries, p_max_outstanding deep, full/empty outputs).

Verification
REQ-032 SHALL test: ports 0,2 valid, memreq_rdy=1, resps_rdy=all 1 -> grants 0,2,0,2 alternate; responses routed 0,2,0,2.
REQ-033 SHALL test: port 1 granted, memreq_rdy=0 3 cycles, port 0 raises val -> grant stays 1 until transfer; port 0 next.
REQ-034 SHALL test: 4 requests accepted, memresp_val=0 -> 5th request stalls (reqs_rdy=0); one pop -> still blocked that cycle, accepted next.
REQ-035 SHALL test: p_num_ports=3, all valid -> grant order 0,1,2,0.
REQ-036 SHALL test: head=port 2, resps_rdy[2]=0, memresp_val=1 -> memresp_rdy=0, no pop, resps_val[2]=1 held.
REQ-037 SHALL test: reset with 3 outstanding -> queue empty, all outputs 0, next grant port 0.

Source files
------------

// File: rtl/vc_mem_port_arbiter_pkg.sv
// Shared types and helpers for vc_mem_port_arbiter: message-size derivation and arbiter state.
package vc_mem_port_arbiter_pkg;

  localparam int c_min_ports = 2;
  localparam int c_max_ports = 8;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Sizes follow the shared memory message layout.
  function automatic int vc_mem_req_msg_sz(input int addr_sz, input int data_sz);
    return 1 + addr_sz + $clog2(data_sz / 8) + data_sz;
  endfunction

  function automatic int vc_mem_resp_msg_sz(input int data_sz);
    return 1 + $clog2(data_sz / 8) + data_sz;
  endfunction

  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/vc_mem_port_arb_id_queue.sv
// In-order FIFO of granted port IDs, used to steer memory responses back to their requester.
module vc_mem_port_arb_id_queue #(
  parameter int p_id_sz = 2,
  parameter int p_depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_val,
  input  logic [p_id_sz-1:0] push_id,
  input  logic               pop,
  output logic [p_id_sz-1:0] head_id,
  output logic               full,
  output logic               empty
);

  localparam int c_ptr_sz = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int c_cnt_sz = c_ptr_sz + 1;

  logic [p_id_sz-1:0]  entries_q [p_depth];
  logic [c_ptr_sz-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_sz-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_sz-1:0] cnt_q, cnt_d;
  logic                do_push, do_pop;

  function automatic logic [c_ptr_sz-1:0] inc_ptr(input logic [c_ptr_sz-1:0] p);
    return (p == c_ptr_sz'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == c_cnt_sz'(p_depth));
  assign empty   = (cnt_q == '0);
  assign head_id = entries_q[rd_ptr_q];
  // A full queue refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push_val && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = inc_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = inc_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/vc_mem_port_arbiter.sv
// Round-robin arbiter merging N requester ports onto one memory port, responses routed in order.
// Define VC_MEM_PORT_ARBITER_ASSERT_EN to enable simulation protocol checks.
module vc_mem_port_arbiter
  import vc_mem_port_arbiter_pkg::*;
#(
  parameter int  p_num_ports       = 4,
  parameter int  p_addr_sz         = 8,
  parameter int  p_data_sz         = 32,
  parameter int  p_max_outstanding = 4,
  localparam int c_req_msg_sz      = vc_mem_req_msg_sz(p_addr_sz, p_data_sz),
  localparam int c_resp_msg_sz     = vc_mem_resp_msg_sz(p_data_sz)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [p_num_ports-1:0]               reqs_val,
  output logic [p_num_ports-1:0]               reqs_rdy,
  input  logic [p_num_ports*c_req_msg_sz-1:0]  reqs_msg,
  output logic [p_num_ports-1:0]               resps_val,
  input  logic [p_num_ports-1:0]               resps_rdy,
  output logic [p_num_ports*c_resp_msg_sz-1:0] resps_msg,
  output logic                                 memreq_val,
  input  logic                                 memreq_rdy,
  output logic [c_req_msg_sz-1:0]              memreq_msg,
  input  logic                                 memresp_val,
  output logic                                 memresp_rdy,
  input  logic [c_resp_msg_sz-1:0]             memresp_msg
);

  localparam int c_id_sz = $clog2(p_num_ports);

  arb_state_e         state_q, state_d;
  logic [c_id_sz-1:0] ptr_q, ptr_d;
  logic [c_id_sz-1:0] grant_q, grant_d;
  logic [c_id_sz-1:0] arb_grant, grant, head_id;
  logic               locked, q_full, q_empty, req_go, resp_go;

  // Scan from the farthest offset down so the nearest valid port at/after ptr wins.
  always_comb begin
    arb_grant = ptr_q;
    for (int i = p_num_ports - 1; i >= 0; i--) begin
      if (reqs_val[c_id_sz'(wrap_idx(int'(ptr_q), i, p_num_ports))])
        arb_grant = c_id_sz'(wrap_idx(int'(ptr_q), i, p_num_ports));
    end
  end

  assign locked     = (state_q == ARB_LOCKED);
  assign grant      = locked ? grant_q : arb_grant;
  assign memreq_val = !reset && ((|reqs_val) || locked) && !q_full;
  assign req_go     = memreq_val && memreq_rdy;

  always_comb begin
    memreq_msg = '0;
    reqs_rdy   = '0;
    for (int i = 0; i < p_num_ports; i++) begin
      if (grant == c_id_sz'(i)) memreq_msg = reqs_msg[i*c_req_msg_sz +: c_req_msg_sz];
    end
    reqs_rdy[grant] = req_go;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_OPEN: begin
        if (memreq_val && !memreq_rdy) begin
          state_d = ARB_LOCKED;
          grant_d = arb_grant;
        end
      end
      ARB_LOCKED: begin
        if (req_go) state_d = ARB_OPEN;
      end
      default: state_d = ARB_OPEN;
    endcase
    if (req_go) ptr_d = (grant == c_id_sz'(p_num_ports - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_OPEN;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  vc_mem_port_arb_id_queue #(
    .p_id_sz (c_id_sz),
    .p_depth (p_max_outstanding)
  ) u_id_queue (
    .clk      (clk),
    .reset    (reset),
    .push_val (req_go),
    .push_id  (grant),
    .pop      (resp_go),
    .head_id  (head_id),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Responses return in request order, so only the queue head may see them.
  always_comb begin
    resps_val          = '0;
    resps_val[head_id] = !reset && memresp_val && !q_empty;
  end

  assign memresp_rdy = !reset && resps_rdy[head_id] && !q_empty;
  assign resp_go     = memresp_val && memresp_rdy;
  assign resps_msg   = {p_num_ports{memresp_msg}};

`ifdef VC_MEM_PORT_ARBITER_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (p_num_ports < c_min_ports || p_num_ports > c_max_ports) begin
        $display("ERROR: vc_mem_port_arbiter p_num_ports=%0d out of range", p_num_ports);
        $finish;
      end
      if (memresp_val && q_empty) begin
        $display("ERROR: vc_mem_port_arbiter memory response with no outstanding request");
        $finish;
      end
      if (locked && !reqs_val[grant_q]) begin
        $display("ERROR: vc_mem_port_arbiter port %0d dropped val while locked", grant_q);
        $finish;
      end
    end
  end
`endif

endmodule
